// File: rtl/emap_pkg.sv
// emap_pkg: shared definitions for the emap memory blocks.
//   Holds the default row geometry (element width, elements per row,
//   highest valid row address and the derived row-address width), the
//   row-writer state encoding and the all-zero row constant. The gather
//   unit (p_emap_8) imports the same package so that both sides agree on
//   the row layout.
package emap_pkg;

  localparam int element_width = 32;
  localparam int no_of_units   = 8;
  localparam int memory_height = 1000;
  localparam int address_width = $clog2(memory_height) + 1;

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_fill  = 2'd1,
    s_write = 2'd2,
    s_done  = 2'd3
  } state_t;

  localparam logic [no_of_units*element_width-1:0] zero_row = '0;

endpackage

// File: rtl/emap_row_packer.sv
// emap_row_packer: slot counter plus row buffer.
//   Elements are packed MSB-first: slot 0 lands in the top element slice,
//   matching the gather unit's column indexing.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       empty the buffer and rewind the slot counter (wins over load)
//   load        store data into the current slot and advance
//   data        element to store
//   row         registered buffer contents
//   row_next    buffer contents including the element being loaded this cycle
//   slot_last   current slot is the last one of the row
module emap_row_packer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [element_width-1:0]             data,
  output logic [no_of_units*element_width-1:0] row,
  output logic [no_of_units*element_width-1:0] row_next,
  output logic                                 slot_last
);

  localparam int slot_w = (no_of_units > 1) ? $clog2(no_of_units) : 1;

  logic [slot_w-1:0] slot;

  assign slot_last = (slot == slot_w'(no_of_units - 1));

  // Combinational view of the buffer with this cycle's element merged in, so
  // the row-closing element can be issued in the very next cycle.
  always_comb begin
    row_next = row;
    if (load) begin
      row_next[(no_of_units - 1 - int'(slot))*element_width +: element_width] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      slot <= '0;
    end else if (clear) begin
      row  <= '0;
      slot <= '0;
    end else if (load) begin
      row  <= row_next;
      slot <= slot_last ? '0 : slot + slot_w'(1);
    end
  end

endmodule

// File: rtl/emap_row_writer.sv
// emap_row_writer: packs a scalar element stream into memory rows and issues
//   each completed row as a single-cycle write.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a transfer (ignored unless idle)
//   base_address      first row address, sampled on start
//   in_valid/in_ready element handshake
//   in_data, in_last  element and end-of-transfer marker
//   write_enable      one-cycle row write strobe
//   write_address     row address, valid with write_enable
//   input_data        packed row, valid with write_enable
//   busy              high from start until done
//   done              one-cycle pulse after the final row write
//   rows_written      rows written in the current or last transfer
//   overflow          sticky: a row was dropped (address past memory_height)
//   fsm_state         current state encoding, for observation
//
// Handshake: an element transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is only high in FILL, in_valid low is a
// stall with no side effects, and the producer must hold in_data/in_last
// stable until the transfer.
module emap_row_writer #(
  parameter int element_width = emap_pkg::element_width,
  parameter int no_of_units   = emap_pkg::no_of_units,
  parameter int memory_height = emap_pkg::memory_height,
  parameter int address_width = emap_pkg::address_width
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic                                 in_valid,
  input  logic [element_width-1:0]             in_data,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic                                 write_enable,
  output logic [address_width-1:0]             write_address,
  output logic [no_of_units*element_width-1:0] input_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [address_width-1:0]             rows_written,
  output logic                                 overflow,
  output logic [1:0]                           fsm_state
);

  import emap_pkg::*;

  localparam int row_w = no_of_units * element_width;
  localparam logic [address_width-1:0] max_row = address_width'(memory_height);

  state_t                   state;
  logic [address_width-1:0] row_ptr;
  logic                     last_row;

  logic             accept;
  logic             close_row;
  logic             pack_clear;
  logic [row_w-1:0] row_buf;
  logic [row_w-1:0] row_next;
  logic             slot_last;

  assign fsm_state  = state;
  assign accept     = (state == s_fill) && in_valid;
  assign close_row  = accept && (slot_last || in_last);
  // The buffer is emptied when a transfer starts and while the closed row is
  // being written, so the next row always begins with all slots zero.
  assign pack_clear = ((state == s_idle) && start) || (state == s_write);

  emap_row_packer #(
    .element_width (element_width),
    .no_of_units   (no_of_units)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .load      (accept),
    .data      (in_data),
    .row       (row_buf),
    .row_next  (row_next),
    .slot_last (slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= s_idle;
      row_ptr       <= '0;
      last_row      <= 1'b0;
      in_ready      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      input_data    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rows_written  <= '0;
      overflow      <= 1'b0;
    end else begin
      write_enable  <= 1'b0;
      write_address <= '0;
      input_data    <= '0;
      done          <= 1'b0;
      case (state)
        s_idle: begin
          if (start) begin
            row_ptr      <= base_address;
            rows_written <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            in_ready     <= 1'b1;
            state        <= s_fill;
          end
        end
        s_fill: begin
          if (close_row) begin
            in_ready <= 1'b0;
            last_row <= in_last;
            state    <= s_write;
            // The strobe is registered on entry so it is high for exactly
            // the WRITE cycle, carrying the row including the closing element.
            if (row_ptr <= max_row) begin
              write_enable  <= 1'b1;
              write_address <= row_ptr;
              input_data    <= row_next;
              rows_written  <= rows_written + address_width'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        s_write: begin
          if (row_ptr != '1) begin
            row_ptr <= row_ptr + address_width'(1);
          end
          if (last_row) begin
            done  <= 1'b1;
            state <= s_done;
          end else begin
            in_ready <= 1'b1;
            state    <= s_fill;
          end
        end
        s_done: begin
          busy  <= 1'b0;
          state <= s_idle;
        end
        default: begin
          state <= s_idle;
        end
      endcase
    end
  end

  // The registered buffer itself is only consumed through row_next.
  logic unused_row;
  assign unused_row = ^row_buf;

endmodule

// File: tb/tb_emap_row_writer.sv
// tb_emap_row_writer: randomized self-checking bench for emap_row_writer.
//   The reference model splits the element list into rows of eight, builds
//   each row word by shifting elements into place, and derives the expected
//   write list, row count, overflow flag and per-cycle handshake trace.
module tb_emap_row_writer;

  localparam int ew = 32;
  localparam int nu = 8;
  localparam int mh = 1000;
  localparam int aw = $clog2(mh) + 1;
  localparam int rw = nu * ew;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [aw-1:0] base_address = '0;
  logic          in_valid = 1'b0;
  logic [ew-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          write_enable;
  logic [aw-1:0] write_address;
  logic [rw-1:0] input_data;
  logic          busy;
  logic          done;
  logic [aw-1:0] rows_written;
  logic          overflow;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  emap_row_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_address  (base_address),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .write_enable  (write_enable),
    .write_address (write_address),
    .input_data    (input_data),
    .busy          (busy),
    .done          (done),
    .rows_written  (rows_written),
    .overflow      (overflow),
    .fsm_state     (fsm_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [ew-1:0] elems[$];
  logic [aw-1:0] exp_addr_q[$];
  logic [rw-1:0] exp_q[$];
  logic [2:0]    exp_trace_q[$];
  int            exp_rows;
  logic          exp_ovf;

  logic [aw-1:0] got_addr_q[$];
  logic [rw-1:0] got_data_q[$];
  logic [2:0]    trace_q[$];
  int            done_cnt = 0;

  // Observation: every write strobe, every done pulse, and the
  // {in_ready, write_enable, done} pattern of every busy cycle.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      got_addr_q.push_back(write_address);
      got_data_q.push_back(input_data);
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) trace_q.push_back({in_ready, write_enable, done});
  end

  task automatic clear_obs();
    got_addr_q.delete();
    got_data_q.delete();
    trace_q.delete();
    done_cnt = 0;
  endtask

  task automatic make_elems(input int n, input bit seq);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back(seq ? ew'(i + 1) : $urandom);
  endtask

  task automatic build_model(input int base, input int n);
    int rows;
    int len;
    int addr;
    logic [rw-1:0] row;
    exp_addr_q.delete();
    exp_q.delete();
    exp_trace_q.delete();
    exp_rows = 0;
    exp_ovf  = 1'b0;
    rows = (n + nu - 1) / nu;
    for (int r = 0; r < rows; r++) begin
      len = (n - r * nu < nu) ? n - r * nu : nu;
      row = '0;
      for (int k = 0; k < len; k++) row = row | (rw'(elems[r*nu+k]) << ((nu - 1 - k) * ew));
      addr = base + r;
      for (int k = 0; k < len; k++) exp_trace_q.push_back(3'b100);
      if (addr <= mh) begin
        exp_addr_q.push_back(aw'(addr));
        exp_q.push_back(row);
        exp_rows++;
        exp_trace_q.push_back(3'b010);
      end else begin
        exp_ovf = 1'b1;
        exp_trace_q.push_back(3'b000);
      end
    end
    exp_trace_q.push_back(3'b001);
  endtask

  // Drives start then streams elems[0..n-1]; gap_pct is the chance (in %)
  // that in_valid is held low in a cycle.
  task automatic run_transfer(input int base, input int n, input int gap_pct, input bit use_last);
    int  i = 0;
    int  guard = 0;
    bit  first = 1'b1;
    bit  v;
    @(negedge clk);
    start = 1'b1;
    base_address = aw'(base);
    while (i < n && guard < 2000) begin
      @(negedge clk);
      if (first) start = 1'b0;
      first = 1'b0;
      guard++;
      v = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? elems[i] : ew'($urandom);
      in_last  = v && use_last && (i == n - 1);
      if (v && in_ready === 1'b1) i++;
    end
    if (i < n) begin
      n_cmp++; n_fail++;
      $display("FAIL stream_timeout: accepted %0d elements, required %0d", i, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (done_cnt == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", g);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({in_ready, write_enable, write_address, input_data, busy, done, rows_written, overflow, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b we=%b addr=%0d busy=%b done=%b rows=%0d ovf=%b state=%0d, required all 0",
               in_ready, write_enable, write_address, busy, done, rows_written, overflow, fsm_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, write_enable, busy, done, rows_written, overflow} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b we=%b busy=%b done=%b rows=%0d ovf=%b, required all 0",
               in_ready, write_enable, busy, done, rows_written, overflow);
    end
  endtask

  task automatic test_single_row();
    make_elems(8, 1'b1);
    build_model(5, 8);
    clear_obs();
    run_transfer(5, 8, 0, 1'b1);
    wait_done();
    n_cmp++;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== 5 || got_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_row_write: %0d writes, first addr %0d data %h, required 1 write addr 5 data %h",
               got_addr_q.size(), got_addr_q.size() ? got_addr_q[0] : '0, got_data_q.size() ? got_data_q[0] : '0, exp_q[0]);
    end
    n_cmp++;
    if (trace_q != exp_trace_q) begin
      n_fail++;
      $display("FAIL single_row_timing: trace of %0d busy cycles differs from required %0d", trace_q.size(), exp_trace_q.size());
    end
    n_cmp++;
    if (rows_written !== 1 || overflow !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL single_row_status: rows=%0d ovf=%b busy=%b dones=%0d, required 1 0 0 1", rows_written, overflow, busy, done_cnt);
    end
  endtask

  task automatic test_partial_row();
    make_elems(11, 1'b1);
    build_model(0, 11);
    clear_obs();
    run_transfer(0, 11, 0, 1'b1);
    wait_done();
    n_cmp++;
    if (got_addr_q.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL partial_row_count: %0d writes, required %0d", got_addr_q.size(), exp_addr_q.size());
    end
    foreach (exp_addr_q[i]) if (i < got_addr_q.size()) begin
      n_cmp++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL partial_row_write%0d: addr %0d data %h, required addr %0d data %h", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (trace_q != exp_trace_q) begin
      n_fail++;
      $display("FAIL partial_row_timing: trace of %0d busy cycles differs from required %0d", trace_q.size(), exp_trace_q.size());
    end
    n_cmp++;
    if (rows_written !== aw'(exp_rows) || overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL partial_row_status: rows=%0d ovf=%b, required %0d %b", rows_written, overflow, exp_rows, exp_ovf);
    end
  endtask

  task automatic test_gaps();
    make_elems(8, 1'b0);
    build_model(3, 8);
    clear_obs();
    run_transfer(3, 8, 40, 1'b1);
    wait_done();
    n_cmp++;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== exp_addr_q[0] || got_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL gaps_write: %0d writes, first addr %0d data %h, required 1 write addr %0d data %h",
               got_addr_q.size(), got_addr_q.size() ? got_addr_q[0] : '0, got_data_q.size() ? got_data_q[0] : '0, exp_addr_q[0], exp_q[0]);
    end
  endtask

  task automatic test_start_ignored();
    make_elems(12, 1'b0);
    build_model(3, 12);
    clear_obs();
    fork
      run_transfer(3, 12, 20, 1'b1);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        base_address = aw'(50);
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (got_addr_q.size() != exp_addr_q.size()) begin
      n_fail++;
      $display("FAIL start_ignored_count: %0d writes, required %0d", got_addr_q.size(), exp_addr_q.size());
    end
    foreach (exp_addr_q[i]) if (i < got_addr_q.size()) begin
      n_cmp++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_ignored_write%0d: addr %0d data %h, required addr %0d data %h", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL start_ignored_restart: busy=%b dones=%0d, required 0 1", busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    make_elems(5, 1'b0);
    clear_obs();
    run_transfer(7, 5, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, write_enable, write_address, input_data, busy, done, rows_written, overflow, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ready=%b we=%b busy=%b done=%b rows=%0d ovf=%b state=%0d, required all 0",
               in_ready, write_enable, busy, done, rows_written, overflow, fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (got_addr_q.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_nowrite: %0d writes %0d dones, required 0 0", got_addr_q.size(), done_cnt);
    end
    make_elems(8, 1'b0);
    build_model(20, 8);
    clear_obs();
    run_transfer(20, 8, 0, 1'b1);
    wait_done();
    n_cmp++;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== exp_addr_q[0] || got_data_q[0] !== exp_q[0] || trace_q != exp_trace_q) begin
      n_fail++;
      $display("FAIL reset_mid_recover: %0d writes, first addr %0d data %h, required 1 write addr %0d data %h",
               got_addr_q.size(), got_addr_q.size() ? got_addr_q[0] : '0, got_data_q.size() ? got_data_q[0] : '0, exp_addr_q[0], exp_q[0]);
    end
  endtask

  task automatic test_overflow();
    make_elems(16, 1'b0);
    build_model(1000, 16);
    clear_obs();
    run_transfer(1000, 16, 0, 1'b1);
    wait_done();
    n_cmp++;
    if (got_addr_q.size() != 1 || got_addr_q[0] !== 1000 || got_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overflow_write: %0d writes, first addr %0d, required 1 write at 1000", got_addr_q.size(), got_addr_q.size() ? got_addr_q[0] : '0);
    end
    n_cmp++;
    if (trace_q != exp_trace_q) begin
      n_fail++;
      $display("FAIL overflow_timing: trace of %0d busy cycles differs from required %0d", trace_q.size(), exp_trace_q.size());
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b1 || rows_written !== 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%b rows=%0d dones=%0d, required 1 1 1", overflow, rows_written, done_cnt);
    end
    make_elems(3, 1'b0);
    build_model(10, 3);
    clear_obs();
    run_transfer(10, 3, 0, 1'b1);
    wait_done();
    n_cmp++;
    if (overflow !== 1'b0 || rows_written !== 1 || got_addr_q.size() != 1 || got_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overflow_cleared: ovf=%b rows=%0d writes=%0d, required 0 1 1", overflow, rows_written, got_addr_q.size());
    end
  endtask

  task automatic test_random();
    int base;
    int n;
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(1005);
      n    = $urandom_range(20, 1);
      make_elems(n, 1'b0);
      build_model(base, n);
      clear_obs();
      run_transfer(base, n, $urandom_range(50), 1'b1);
      wait_done();
      n_cmp++;
      if (got_addr_q.size() != exp_addr_q.size()) begin
        n_fail++;
        $display("FAIL random%0d_count: %0d writes, required %0d (base %0d, n %0d)", it, got_addr_q.size(), exp_addr_q.size(), base, n);
      end
      foreach (exp_addr_q[i]) if (i < got_addr_q.size()) begin
        n_cmp++;
        if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random%0d_write%0d: addr %0d data %h, required addr %0d data %h", it, i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (rows_written !== aw'(exp_rows) || overflow !== exp_ovf || done_cnt != 1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d_status: rows=%0d ovf=%b dones=%0d busy=%b, required %0d %b 1 0", it, rows_written, overflow, done_cnt, busy, exp_rows, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_partial_row();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/emap_row_writer.md
# emap_row_writer

Write-side companion to the 8-wide vector memory gather unit (p_emap_8). Accepts a stream of scalar results, one element per cycle, and packs them into `no_of_units`-element memory rows. Each completed row is issued as a single-cycle write on the memory's `write_enable` / `write_address` / `input_data` port. Element packing matches the gather unit's read indexing, so element `c` of the stream is later fetched by column number `c` (relative to the base row).

## Interface
Parameters:
- `element_width`, 32, bits per scalar element
- `no_of_units`, 8, elements per memory row
- `memory_height`, 1000, highest valid row address (memory holds rows 0..`memory_height`)
- `address_width`, `$clog2(memory_height)+1`, row address width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a transfer; ignored unless idle
- `base_address`  in  `address_width`  first row address; sampled on `start`
- `in_valid`  in  1  `in_data` is valid
- `in_data`  in  `element_width`  scalar element
- `in_last`  in  1  qualifies the final element of the transfer
- `in_ready`  out  1  element accepted when `in_valid && in_ready`
- `write_enable`  out  1  one-cycle row write strobe, to the memory write port
- `write_address`  out  `address_width`  row address, valid with `write_enable`
- `input_data`  out  `no_of_units*element_width`  packed row, valid with `write_enable`
- `busy`  out  1  high from `start` until `done`
- `done`  out  1  one-cycle pulse after the final row write
- `rows_written`  out  `address_width`  rows written in the current or last transfer
- `overflow`  out  1  sticky; a row was dropped because its address exceeded `memory_height`

## Operation
State machine: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `in_ready` = 0.
  - On `start`: latch `base_address` into the row pointer; clear the slot counter, row buffer, `rows_written` and `overflow`; go to FILL.
- **FILL**
  - `in_ready` = 1.
  - Each accepted element goes to slot `k` (0..`no_of_units`-1), at bits `[(no_of_units-k)*element_width-1 -: element_width]`. Slot 0 is the MSB slice.
  - Go to WRITE when slot `no_of_units`-1 is filled, or when an element with `in_last` is accepted.
  - Unfilled slots of a partial row are zero.
- **WRITE** (exactly 1 cycle)
  - `in_ready` = 0.
  - If row pointer ≤ `memory_height`: `write_enable` = 1, `write_address` = row pointer, `input_data` = buffer, and `rows_written` increments.
  - Otherwise: no strobe, and `overflow` is set.
  - Row pointer increments; buffer and slot counter clear.
  - Next state: DONE if the row was closed by `in_last`, else FILL.
- **DONE** (1 cycle)
  - `done` = 1.
  - Go to IDLE.
- `busy` = (state ≠ IDLE).
- `start` during a non-IDLE state is ignored.
- `in_valid` while idle is not accepted.
- Arithmetic:
  - Row pointer is `address_width` bits, unsigned, and saturates at all-ones.
  - Overflow is checked with an unsigned compare against `memory_height`.

## Timing
- Reset values: every output is 0 (`in_ready`, `write_enable`, `write_address`, `input_data`, `busy`, `done`, `rows_written`, `overflow`); state = IDLE; buffer = 0.
- `start` at edge T → `busy` and `in_ready` high from T+1.
- Row-closing element accepted at edge N → `write_enable` high for the cycle after N. The memory captures the row at edge N+1, so a read issued by the gather unit from edge N+2 onward sees the new data.
- Throughput: one bubble per row, i.e. `no_of_units` elements per `no_of_units`+1 cycles at full `in_valid`.
- `done` asserts the cycle after the final WRITE; `busy` falls together with `done`.
- `in_last` on slot `no_of_units`-1 → a single full-row write, no extra empty row.
- `in_valid` gaps in FILL stall without side effects.
- Reset asserted mid-transfer aborts immediately: no write is issued, the buffer is lost, and all outputs go to their reset values.

## Structure
- Shared package `emap_pkg`:
  - `element_width`, `no_of_units`, `memory_height`, and the derived `address_width`
  - the state enum (IDLE/FILL/WRITE/DONE)
  - the zero-row constant
  - This package is also used by p_emap_8 to keep the row layout in one place.
- One sub-module `emap_row_packer`: slot counter plus row buffer with clear and load. It is instantiated once.
- FSM, row pointer and status flags stay in the top level.

## Test plan
- Base 5, elements 1..8 at full rate, `in_last` on 8 → one write at addr 5, data {1,2,3,4,5,6,7,8} with 1 in the MSB slice; `done` 1 cycle later; `rows_written` = 1.
- Base 0, elements 1..11, `in_last` on 11 → writes at addr 0 {1..8} and addr 1 {9,10,11,0,0,0,0,0}; `in_ready` low exactly 1 cycle after element 8; `rows_written` = 2.
- Base 3, 8 elements with random `in_valid` gaps → same row data as at full rate, written at addr 3; no spurious `write_enable`.
- `start` pulsed with base 50 while busy with base 3 → writes only at 3 and up; base 50 is never used.
- Reset pulsed after 5 elements accepted → no write; all outputs 0; a new `start` then works normally.
- Base 1000, 16 elements, `in_last` on 16 → write at 1000 only; second row dropped; `overflow` = 1 and stays set until the next `start`; `done` still pulses.
